// File: rtl/ccff_loader_pkg.sv
// Shared types and default sizing for the ccff chain loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift
  } state_e;

  localparam int unsigned DefaultChainLen = 64;
  localparam int unsigned DefaultWordW    = 8;

endpackage

// File: rtl/ccff_word_serializer.sv
// Holds one bitstream word and emits it MSB first; flags the last bit of the word.
module ccff_word_serializer
  import ccff_loader_pkg::*;
#(
  parameter int unsigned WORD_W = DefaultWordW
) (
  input  logic              prog_clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              shift,
  input  logic              clear,
  output logic              msb,
  output logic              last_bit
);

  localparam int unsigned BitW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BitW-1:0] LastBit = BitW'(WORD_W - 1);

  logic [WORD_W-1:0] word_q;
  logic [BitW-1:0]   bit_q;

  always_ff @(posedge prog_clk) begin
    if (!reset || clear) begin
      word_q <= '0;
      bit_q  <= '0;
    end else if (load) begin
      word_q <= load_data;
      bit_q  <= '0;
    end else if (shift) begin
      word_q <= word_q << 1;
      bit_q  <= bit_q + 1'b1;
    end
  end

  assign msb      = word_q[WORD_W-1];
  assign last_bit = (bit_q == LastBit);

endmodule

// File: rtl/ccff_chain_loader.sv
// Streams bitstream words into a ccff chain (load) or checks the chain tail against them (verify).
// Optional CCFF_LOADER_MISMATCH_CNT_EN adds a saturating per-pass mismatch counter output.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = DefaultChainLen,
  parameter int unsigned WORD_W    = DefaultWordW
) (
  input  logic              prog_clk,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic              cfg_verify,
  input  logic              cfg_abort,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_shift,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef CCFF_LOADER_MISMATCH_CNT_EN
  ,
  output logic [7:0]        mismatch_cnt
`endif
);

  localparam int unsigned CntW = $clog2(CHAIN_LEN + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(CHAIN_LEN - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] total_q, total_d;
  logic            verify_q, verify_d;
  logic            err_q, err_d;
  logic            ser_load, ser_shift, ser_clear, ser_msb, ser_last;
  logic            mismatch;

  ccff_word_serializer #(
    .WORD_W(WORD_W)
  ) u_serializer (
    .prog_clk (prog_clk),
    .reset    (reset),
    .load     (ser_load),
    .load_data(s_data),
    .shift    (ser_shift),
    .clear    (ser_clear),
    .msb      (ser_msb),
    .last_bit (ser_last)
  );

  always_comb begin
    state_d    = state_q;
    total_d    = total_q;
    verify_d   = verify_q;
    err_d      = err_q;
    s_ready    = 1'b0;
    ccff_shift = 1'b0;
    ccff_head  = 1'b0;
    done       = 1'b0;
    ser_load   = 1'b0;
    ser_shift  = 1'b0;
    ser_clear  = 1'b0;
    mismatch   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cfg_start) begin
          state_d  = StLoad;
          verify_d = cfg_verify;
          err_d    = 1'b0;
          total_d  = '0;
        end
      end

      StLoad: begin
        // Abort wins over a same-cycle handshake, so ready is withheld.
        if (cfg_abort) begin
          state_d   = StIdle;
          total_d   = '0;
          ser_clear = 1'b1;
        end else begin
          s_ready = 1'b1;
          if (s_valid) begin
            ser_load = 1'b1;
            state_d  = StShift;
          end
        end
      end

      StShift: begin
        if (cfg_abort) begin
          state_d   = StIdle;
          total_d   = '0;
          ser_clear = 1'b1;
        end else begin
          ccff_shift = 1'b1;
          ccff_head  = ser_msb;
          ser_shift  = 1'b1;
          total_d    = total_q + 1'b1;
          mismatch   = verify_q && (ccff_tail != ser_msb);
          if (mismatch) err_d = 1'b1;
          // Chain length ends the pass even mid-word; leftover low bits are dropped.
          if (total_q == LastCnt) begin
            state_d = StIdle;
            done    = 1'b1;
            total_d = '0;
          end else if (ser_last) begin
            state_d = StLoad;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      total_q  <= '0;
      verify_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      total_q  <= total_d;
      verify_q <= verify_d;
      err_q    <= err_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign err  = err_q;

`ifdef CCFF_LOADER_MISMATCH_CNT_EN
  logic [7:0] mm_q;

  always_ff @(posedge prog_clk) begin
    if (!reset) begin
      mm_q <= '0;
    end else if (state_q == StIdle && cfg_start) begin
      mm_q <= '0;
    end else if (mismatch && mm_q != 8'hFF) begin
      mm_q <= mm_q + 1'b1;
    end
  end

  assign mismatch_cnt = mm_q;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader with a 10-bit chain model, 4-bit words.
module tb_ccff_chain_loader;

  localparam int unsigned CL = 10;
  localparam int unsigned WW = 4;

  logic          prog_clk = 1'b0;
  logic          reset = 1'b0;
  logic          cfg_start = 1'b0;
  logic          cfg_verify = 1'b0;
  logic          cfg_abort = 1'b0;
  logic [WW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready, ccff_head, ccff_shift, ccff_tail, busy, done, err;
`ifdef CCFF_LOADER_MISMATCH_CNT_EN
  logic [7:0]    mismatch_cnt;
`endif

  ccff_chain_loader #(
    .CHAIN_LEN(CL),
    .WORD_W   (WW)
  ) dut (
    .prog_clk  (prog_clk),
    .reset     (reset),
    .cfg_start (cfg_start),
    .cfg_verify(cfg_verify),
    .cfg_abort (cfg_abort),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .ccff_head (ccff_head),
    .ccff_shift(ccff_shift),
    .ccff_tail (ccff_tail),
    .busy      (busy),
    .done      (done),
    .err       (err)
`ifdef CCFF_LOADER_MISMATCH_CNT_EN
    ,
    .mismatch_cnt(mismatch_cnt)
`endif
  );

  always #5 prog_clk = ~prog_clk;

  // Chain model: head enters at index 0, tail leaves from index CL-1.
  logic [CL-1:0] chain = '0;
  logic          sh_s = 1'b0, hd_s = 1'b0;
  int            shift_cnt = 0;
  bit            flip_en = 1'b0;
  int            flip_idx = -1;
  int            flip_base = 0;

  assign ccff_tail = chain[CL-1] ^ (flip_en && ((shift_cnt - flip_base) == flip_idx));

  always @(posedge prog_clk) begin
    if (sh_s) begin
      chain     <= {chain[CL-2:0], hd_s};
      shift_cnt <= shift_cnt + 1;
    end
  end

  // Mid-cycle observation of DUT outputs.
  int          nshift = 0, nready = 0, ndone = 0, ngap = 0, done_at = 0;
  logic [63:0] hist = '0;
  bit          in_gap = 1'b0;

  always @(negedge prog_clk) begin
    sh_s <= ccff_shift;
    hd_s <= ccff_head;
    if (ccff_shift) begin
      nshift <= nshift + 1;
      hist   <= {hist[62:0], ccff_head};
      if (in_gap) ngap <= ngap + 1;
    end
    if (s_ready) nready <= nready + 1;
    if (done) begin
      ndone   <= ndone + 1;
      done_at <= nshift + (ccff_shift ? 1 : 0);
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic send_word(input logic [WW-1:0] w, input int gaps, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge prog_clk);
      if (s_ready) seen = 1'b1;
      else step();
    end
    chk({tag, "_ready_seen"}, 32'(seen), 32'd1);
    in_gap = 1'b1;
    repeat (gaps) step();
    in_gap  = 1'b0;
    s_data  = w;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
  endtask

  task automatic start_pass(input bit verify, input int flip);
    flip_base  = shift_cnt;
    flip_idx   = flip;
    flip_en    = (flip >= 0);
    cfg_start  = 1'b1;
    cfg_verify = verify;
    step();
    cfg_start  = 1'b0;
    cfg_verify = 1'b0;
  endtask

  task automatic run_pass(input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                          input logic [WW-1:0] w2, input bit verify, input int flip,
                          input int gaps, input logic [CL-1:0] exp_head, input bit exp_err,
                          input int exp_mm, input string tag);
    int b_sh, b_rd, b_dn, b_gp;
    bit got = 1'b0;
    b_sh = nshift;
    b_rd = nready;
    b_dn = ndone;
    b_gp = ngap;
    start_pass(verify, flip);
    chk({tag, "_err_clr"}, 32'(err), 32'd0);
    send_word(w0, gaps, tag);
    send_word(w1, gaps, tag);
    send_word(w2, gaps, tag);
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge prog_clk);
      if (done) got = 1'b1;
      else step();
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    step();
    chk({tag, "_shifts"}, 32'(nshift - b_sh), 32'(CL));
    chk({tag, "_ready_cyc"}, 32'(nready - b_rd), 32'(3 * (gaps + 1)));
    chk({tag, "_done_cnt"}, 32'(ndone - b_dn), 32'd1);
    chk({tag, "_done_at"}, 32'(done_at - b_sh), 32'(CL));
    chk({tag, "_gap_shift"}, 32'(ngap - b_gp), 32'd0);
    chk({tag, "_head"}, 32'(hist[CL-1:0]), 32'(exp_head));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
`ifdef CCFF_LOADER_MISMATCH_CNT_EN
    chk({tag, "_mm"}, 32'(mismatch_cnt), 32'(exp_mm));
`endif
    flip_en = 1'b0;
  endtask

  typedef struct {
    logic [WW-1:0] w0, w1, w2;
    bit            verify;
    int            flip;
    int            gaps;
    logic [CL-1:0] head;
    bit            err;
    int            mm;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{4'hA, 4'h5, 4'hC, 1'b0, -1, 0, 10'b1010010111, 1'b0, 0};
    vecs[1] = '{4'hA, 4'h5, 4'hC, 1'b1, -1, 0, 10'b1010010111, 1'b0, 0};
    vecs[2] = '{4'hA, 4'h5, 4'hC, 1'b1, 4, 0, 10'b1010010111, 1'b1, 1};
    vecs[3] = '{4'h3, 4'hF, 4'h0, 1'b0, -1, 1, 10'b0011111100, 1'b0, 0};
    vecs[4] = '{4'h3, 4'hF, 4'h4, 1'b1, -1, 0, 10'b0011111101, 1'b1, 1};
    vecs[5] = '{4'h3, 4'hF, 4'h4, 1'b1, 9, 2, 10'b0011111101, 1'b1, 1};

    repeat (3) @(posedge prog_clk);
    #1;
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_shift", 32'(ccff_shift), 32'd0);
    chk("rst_head", 32'(ccff_head), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b1;
    step();
    chk("idle_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_pass(vecs[i].w0, vecs[i].w1, vecs[i].w2, vecs[i].verify, vecs[i].flip, vecs[i].gaps,
               vecs[i].head, vecs[i].err, vecs[i].mm, $sformatf("vec%0d", i));
    end

    // Abort on the second shift of word 0x5.
    begin
      int b_sh, b_dn;
      b_sh = nshift;
      b_dn = ndone;
      start_pass(1'b0, -1);
      send_word(4'hA, 0, "abort");
      send_word(4'h5, 0, "abort");
      step();
      cfg_abort = 1'b1;
      @(negedge prog_clk);
      chk("abort_cycle_shift", 32'(ccff_shift), 32'd0);
      chk("abort_cycle_done", 32'(done), 32'd0);
      step();
      cfg_abort = 1'b0;
      chk("abort_next_shift", 32'(ccff_shift), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_no_done", 32'(ndone - b_dn), 32'd0);
      chk("abort_shifts", 32'(nshift - b_sh), 32'd5);
      run_pass(4'hA, 4'h5, 4'hC, 1'b0, -1, 0, 10'b1010010111, 1'b0, 0, "post_abort");
    end

    // Reset in the middle of a failing verify pass, then a gapped rerun.
    begin
      int b_dn;
      b_dn = ndone;
      start_pass(1'b1, 0);
      send_word(4'h5, 0, "rstmid");
      step();
      step();
      chk("rstmid_err_set", 32'(err), 32'd1);
      reset = 1'b0;
      step();
      chk("rstmid_ready", 32'(s_ready), 32'd0);
      chk("rstmid_shift", 32'(ccff_shift), 32'd0);
      chk("rstmid_head", 32'(ccff_head), 32'd0);
      chk("rstmid_busy", 32'(busy), 32'd0);
      chk("rstmid_done", 32'(done), 32'd0);
      chk("rstmid_err", 32'(err), 32'd0);
`ifdef CCFF_LOADER_MISMATCH_CNT_EN
      chk("rstmid_mm", 32'(mismatch_cnt), 32'd0);
`endif
      reset   = 1'b1;
      flip_en = 1'b0;
      step();
      chk("rstmid_no_done", 32'(ndone - b_dn), 32'd0);
      run_pass(4'hA, 4'h5, 4'hC, 1'b0, -1, 3, 10'b1010010111, 1'b0, 0, "gap_rerun");
    end

    // Random passes against a bit-stream reference computed from the chain snapshot.
    for (int r = 0; r < 24; r++) begin
      logic [WW-1:0]   w0, w1, w2;
      logic [3*WW-1:0] stream;
      logic [CL-1:0]   exp_head, snap;
      bit              v;
      int              flip, mm, gaps;
      w0     = WW'($urandom);
      w1     = WW'($urandom);
      w2     = WW'($urandom);
      v      = 1'($urandom_range(0, 1));
      flip   = (v && $urandom_range(0, 2) != 0) ? int'($urandom_range(0, CL - 1)) : -1;
      gaps   = int'($urandom_range(0, 2));
      stream = {w0, w1, w2};
      exp_head = stream[3*WW-1 -: CL];
      snap   = chain;
      mm     = 0;
      if (v) begin
        for (int k = 0; k < CL; k++) begin
          if (exp_head[CL-1-k] != (snap[CL-1-k] ^ (k == flip))) mm++;
        end
      end
      run_pass(w0, w1, w2, v, flip, gaps, exp_head, mm > 0, mm, $sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ccff_chain_loader.md
CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 64: number of configuration flip-flops in the target ccff chain (>= 1).
REQ-002 SHALL have parameter WORD_W, default 8: width of input bitstream words (>= 1).
REQ-003 SHALL use one clock and a synchronous, active-low reset.
REQ-004 SHALL have port prog_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port cfg_start, input, 1 bit: start a pass; sampled only in IDLE.
REQ-007 SHALL have port cfg_verify, input, 1 bit: sampled with cfg_start; 1 selects a verify pass, 0 a load pass.
REQ-008 SHALL have port cfg_abort, input, 1 bit: abandon the current pass.
REQ-009 SHALL have port s_data, input, WORD_W bits: bitstream word, shifted MSB first.
REQ-010 SHALL have port s_valid, input, 1 bit, and port s_ready, output, 1 bit: word handshake; transfer when both are 1.
REQ-011 SHALL have port ccff_head, output, 1 bit: serial data to the chain head.
REQ-012 SHALL have port ccff_shift, output, 1 bit: chain shift enable; the chain advances one position on each edge where it is 1.
REQ-013 SHALL have port ccff_tail, input, 1 bit: serial data from the chain tail.
REQ-014 SHALL have port busy, output, 1 bit: state is not IDLE.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse when a pass completes normally.
REQ-016 SHALL have port err, output, 1 bit: sticky verify mismatch flag.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD and SHIFT.
  - IDLE -> LOAD on cfg_start.
  - LOAD -> SHIFT on handshake.
  - SHIFT -> LOAD when the word is exhausted and total bits < CHAIN_LEN.
  - SHIFT -> IDLE when total bits = CHAIN_LEN; done pulses that same cycle.
REQ-018 SHALL set s_ready=1 only in LOAD; the handshake cycle itself SHALL NOT shift.
REQ-019 SHALL, in SHIFT, assert ccff_shift=1 every cycle with ccff_head = current MSB of the word register, then left-shift the word register and increment the bit counter (width clog2(CHAIN_LEN+1)).
REQ-020 SHALL shift exactly min(WORD_W, CHAIN_LEN - bits_done) bits per word; unused low bits of the final word SHALL be discarded.
REQ-021 SHALL drive ccff_shift=0 and ccff_head=0 in IDLE and LOAD.
REQ-022 SHALL, on a verify pass, compare ccff_tail with ccff_head in every shift cycle before the edge; any mismatch sets err. A correctly loaded chain returns the same stream in order.
REQ-023 SHALL clear err on cfg_start; err SHALL hold its value otherwise, including through abort.
REQ-024 SHALL ignore cfg_start while busy.
REQ-025 SHALL, on cfg_abort in LOAD or SHIFT, go to IDLE next cycle with no shift in that cycle, no done, and counter cleared; cfg_abort has priority over a handshake in the same cycle.
REQ-026 SHALL let gaps in s_valid stall in LOAD indefinitely with no shifts.

Reset
REQ-027 SHALL, while reset=0 at an edge, enter IDLE, clear the counter and word register, and set s_ready=0, ccff_shift=0, ccff_head=0, busy=0, done=0, err=0; reset mid-pass abandons the pass without done.

Configuration
REQ-028 SHALL, with macro CCFF_LOADER_MISMATCH_CNT_EN defined, add output mismatch_cnt (8 bits): it counts verify mismatches in the current pass, saturates at 255 and clears on cfg_start and reset.
REQ-029 SHALL, without CCFF_LOADER_MISMATCH_CNT_EN, omit the port and counter; err is unaffected either way.

Structure
REQ-030 SHALL place the FSM state enum and default CHAIN_LEN/WORD_W constants in shared package ccff_loader_pkg.
REQ-031 SHALL implement the word register and per-word bit count as sub-module ccff_word_serializer; the top holds the FSM, total counter and verify logic.

Verification (CHAIN_LEN=10, WORD_W=4)
REQ-032 Load pass, words 0xA, 0x5, 0xC, s_valid held high -> ccff_head over shift cycles = 1010 0101 11; exactly 10 ccff_shift cycles; done pulses on the 10th shift; s_ready=1 exactly 3 cycles.
REQ-033 Verify pass with the same words against a 10-bit chain model loaded by REQ-032 -> err=0, done pulses; with the macro defined, mismatch_cnt=0.
REQ-034 Verify pass with model tail bit 4 forced inverted -> err=1 after that shift and still 1 after done; with the macro defined, mismatch_cnt=1.
REQ-035 cfg_abort asserted on the 2nd shift of word 0x5 -> ccff_shift=0 the next cycle, busy=0, no done; a following load pass completes in 10 shifts.
REQ-036 reset=0 during SHIFT, plus s_valid gaps of 3 cycles between words on a rerun -> all outputs 0 after reset; the rerun shows no shifts during gaps and the same head sequence as REQ-032.
